// File: rtl/axi_wr_fill_seq_if.sv
// AXI4 write-channel bundle (AW/W/B) shared by the fill sequencer and its slave.
interface axi_wr_fill_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/axi_wr_fill_seq.sv
// AXI4 write fill sequencer: writes an incrementing pattern over a word range,
// one INCR burst outstanding at a time, bursts split at MAX_BURST and 4 KB lines.
//
// state  | meaning
// IDLE   | waiting for start
// AW     | presenting the burst address
// W      | streaming burst beats, WLAST on the final one
// B      | waiting for the write response
// DONE   | job finished; done pulses and busy drops on exit
module axi_wr_fill_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_words,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  axi_wr_fill_seq_if.master     axi
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [12:0] bytes_to_4k;
  logic [16:0] words_to_4k;
  logic [16:0] lim;
  logic [8:0]  beats_w;
  logic        unused_bits;

  // Burst length only depends on registered address/remaining count, so the
  // AW fields stay stable for as long as AWVALID is held.
  always_comb begin
    bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
    words_to_4k = 17'(bytes_to_4k >> SIZE);
    lim = {1'b0, rem_q};
    if (lim > 17'(MAX_BURST)) begin
      lim = 17'(MAX_BURST);
    end
    if (lim > words_to_4k) begin
      lim = words_to_4k;
    end
  end

  assign beats_w     = lim[8:0];
  assign unused_bits = ^{lim[16:9], axi.BID};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    data_d     = data_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (num_words != 16'd0) begin
            addr_d  = base_addr & ALIGN_MASK;
            rem_d   = num_words;
            data_d  = fill_data;
            state_d = S_AW;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_AW: begin
        if (axi.AWREADY) begin
          beats_d    = beats_w;
          beat_cnt_d = beats_w;
          state_d    = S_W;
        end
      end

      S_W: begin
        if (axi.WREADY) begin
          data_d     = data_q + 1'b1;
          beat_cnt_d = beat_cnt_q - 9'd1;
          if (beat_cnt_q == 9'd1) begin
            state_d = S_B;
          end
        end
      end

      S_B: begin
        if (axi.BVALID) begin
          if (axi.BRESP != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
            rem_d  = rem_q - {7'd0, beats_q};
            if (rem_q == {7'd0, beats_q}) begin
              state_d = S_DONE;
            end else begin
              state_d = S_AW;
            end
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign axi.AWID    = ID_WIDTH'(0);
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = 8'(beats_w - 9'd1);
  assign axi.AWSIZE  = 3'(SIZE);
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = (state_q == S_AW);

  assign axi.WDATA   = data_q;
  assign axi.WSTRB   = '1;
  assign axi.WLAST   = (state_q == S_W) && (beat_cnt_q == 9'd1);
  assign axi.WVALID  = (state_q == S_W);

  assign axi.BREADY  = (state_q == S_B);

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
